// File: rtl/wrr_pkg.sv
// Shared constants for the weighted round-robin arbiter.
//   MODE_RR / MODE_WRR : encodings of the MODE input
//   WRR_DEFAULT_WEIGHT : weight loaded into every table entry at reset
package wrr_pkg;
  localparam logic MODE_RR            = 1'b0;
  localparam logic MODE_WRR           = 1'b1;
  localparam int   WRR_DEFAULT_WEIGHT = 1;
endpackage

// File: rtl/rr_next_finder.sv
// Combinational round-robin search.
//   eligible : per-channel eligibility mask
//   ptr      : channel that was granted last
//   found    : at least one channel is eligible
//   idx      : first eligible channel after ptr, wrapping; ptr itself is checked last
module rr_next_finder #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    idx   = ptr;
    // Offsets 1..NUM_CH; offset NUM_CH lands back on ptr. Explicit wrap
    // keeps this correct for non-power-of-2 channel counts.
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!found && eligible[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter for the QoS transmit path.
//   CLK, RESET_L : clock, synchronous active-low reset
//   ENB          : arbitration enable (0 freezes ptr/credit, no grant)
//   MODE         : MODE_RR plain round-robin, MODE_WRR weighted
//   REQ          : per-channel level request
//   TAB_WR, TAB  : weight table load; entry c = TAB[c*WEIGHT_W +: WEIGHT_W]
//   GNT, GNT_IDX, GNT_VLD : registered one-hot grant, its index, valid
//   CREDIT       : grants left in the current channel's turn
// Handshake: GNT/GNT_IDX are meaningful only while GNT_VLD=1; there is no
// back-pressure, a grant is consumed in the cycle it is presented.
module weighted_rr_arbiter
  import wrr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 8,
  parameter int IDX_W    = $clog2(NUM_CH)
) (
  input  logic                       CLK,
  input  logic                       RESET_L,
  input  logic                       ENB,
  input  logic                       MODE,
  input  logic [NUM_CH-1:0]          REQ,
  input  logic                       TAB_WR,
  input  logic [NUM_CH*WEIGHT_W-1:0] TAB,
  output logic [NUM_CH-1:0]          GNT,
  output logic [IDX_W-1:0]           GNT_IDX,
  output logic                       GNT_VLD,
  output logic [WEIGHT_W-1:0]        CREDIT
);

  logic [WEIGHT_W-1:0] weight_q [NUM_CH];
  logic [WEIGHT_W-1:0] weight_d [NUM_CH];
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic                gnt_vld_q, gnt_vld_d;

  logic [NUM_CH-1:0]   eligible;
  logic                nxt_found;
  logic [IDX_W-1:0]    nxt_idx;

  // Zero-weight channels drop out only in weighted mode.
  always_comb begin
    eligible = REQ;
    if (MODE == MODE_WRR) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (weight_q[c] == '0) eligible[c] = 1'b0;
      end
    end
  end

  rr_next_finder #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_finder (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (nxt_found),
    .idx      (nxt_idx)
  );

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      weight_d[c] = TAB_WR ? TAB[c*WEIGHT_W +: WEIGHT_W] : weight_q[c];
    end
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    gnt_d     = '0;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = 1'b0;
    if (ENB) begin
      if (credit_q != '0 && eligible[ptr_q]) begin
        // Continue the current turn.
        gnt_d     = NUM_CH'(1) << ptr_q;
        gnt_idx_d = ptr_q;
        gnt_vld_d = 1'b1;
        credit_d  = credit_q - WEIGHT_W'(1);
      end else if (nxt_found) begin
        // New turn: credit excludes the grant issued now. The weight is
        // nonzero here in weighted mode, so the subtraction cannot wrap.
        gnt_d     = NUM_CH'(1) << nxt_idx;
        gnt_idx_d = nxt_idx;
        gnt_vld_d = 1'b1;
        ptr_d     = nxt_idx;
        credit_d  = (MODE == MODE_WRR) ? weight_q[nxt_idx] - WEIGHT_W'(1) : '0;
      end else begin
        credit_d  = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      for (int c = 0; c < NUM_CH; c++) weight_q[c] <= WEIGHT_W'(WRR_DEFAULT_WEIGHT);
      ptr_q     <= IDX_W'(NUM_CH - 1);
      credit_q  <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) weight_q[c] <= weight_d[c];
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_IDX = gnt_idx_q;
  assign GNT_VLD = gnt_vld_q;
  assign CREDIT  = credit_q;

endmodule
